sync_fifo_param: RTL and testbench

- Parametrised single-clock FIFO; next generation of the team's 32x1024 FIFO.
- Adds configurable width and depth, an occupancy count, almost-full/almost-empty thresholds, sticky overflow/underflow error flags, a synchronous flush and an output-valid strobe.
- Sits between producer and consumer stages in the same clock domain.

---
 rtl/sync_fifo_param.sv | 110 +++++++++++
 tb/tb_sync_fifo_param.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_param.sv
`timescale 1ns/1ps
// sync_fifo_param: parametrised single-clock FIFO with occupancy count, thresholds,
// sticky overflow/underflow flags and flush. Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads.
module sync_fifo_param #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 10,
    parameter int AF_LEVEL = 2**ADDR_W - 2,
    parameter int AE_LEVEL = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              w_en,
    input  logic              r_en,
    input  logic              flush,
    input  logic              clr_err,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              dout_valid,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow
);
    localparam int              DEPTH   = 2**ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_C = DEPTH[ADDR_W:0];
    localparam logic [ADDR_W:0] AF_C    = AF_LEVEL[ADDR_W:0];
    localparam logic [ADDR_W:0] AE_C    = AE_LEVEL[ADDR_W:0];
    localparam logic [ADDR_W:0] PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};

    logic [DATA_W-1:0] mem [0:DEPTH-1];
    logic [ADDR_W:0]   w_ptr_reg;
    logic [ADDR_W:0]   r_ptr_reg;
    logic              overflow_reg;
    logic              underflow_reg;
    logic              wr_acc;
    logic              rd_acc;
    logic              ovf_evt;
    logic              unf_evt;

    // Pointers carry a wrap bit, so their difference is the true occupancy 0..DEPTH.
    assign count        = w_ptr_reg - r_ptr_reg;
    assign full         = (count == DEPTH_C);
    assign empty        = (count == '0);
    assign almost_full  = (count >= AF_C);
    assign almost_empty = (count <= AE_C);
    assign overflow     = overflow_reg;
    assign underflow    = underflow_reg;

    assign wr_acc  = w_en && !full  && !flush;
    assign rd_acc  = r_en && !empty && !flush;
    assign ovf_evt = w_en && full   && !flush;
    assign unf_evt = r_en && empty  && !flush;

    always_ff @(posedge clk) begin
        if (rst && wr_acc) begin
            mem[w_ptr_reg[ADDR_W-1:0]] <= data_in;
        end
    end

    // Flush empties the FIFO but deliberately leaves the error flags untouched.
    always_ff @(posedge clk) begin
        if (!rst) begin
            w_ptr_reg     <= '0;
            r_ptr_reg     <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else if (flush) begin
            w_ptr_reg <= '0;
            r_ptr_reg <= '0;
        end else begin
            if (wr_acc) begin
                w_ptr_reg <= w_ptr_reg + PTR_ONE;
            end
            if (rd_acc) begin
                r_ptr_reg <= r_ptr_reg + PTR_ONE;
            end
            overflow_reg  <= ovf_evt || (overflow_reg  && !clr_err);
            underflow_reg <= unf_evt || (underflow_reg && !clr_err);
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    assign data_out   = mem[r_ptr_reg[ADDR_W-1:0]];
    assign dout_valid = !empty;
`else
    logic [DATA_W-1:0] data_out_reg;
    logic              dout_valid_reg;

    always_ff @(posedge clk) begin
        if (!rst) begin
            data_out_reg   <= '0;
            dout_valid_reg <= 1'b0;
        end else if (flush) begin
            dout_valid_reg <= 1'b0;
        end else begin
            dout_valid_reg <= rd_acc;
            if (rd_acc) begin
                data_out_reg <= mem[r_ptr_reg[ADDR_W-1:0]];
            end
        end
    end

    assign data_out   = data_out_reg;
    assign dout_valid = dout_valid_reg;
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
`timescale 1ns/1ps
// tb_sync_fifo_param: randomized bench for sync_fifo_param checked against a queue-based model.
module tb_sync_fifo_param;
    localparam int DW    = 32;
    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam int AFL   = 14;
    localparam int AEL   = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          w_en = 1'b0;
    logic          r_en = 1'b0;
    logic          flush = 1'b0;
    logic          clr_err = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic [DW-1:0] data_out;
    logic          dout_valid;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          almost_empty;
    logic [AW:0]   count;
    logic          overflow;
    logic          underflow;
    logic [10:0]   dut_flags;

    int total = 0;
    int bad   = 0;

    // Reference model: queue of stored words plus the registered read outputs and error flags.
    logic [DW-1:0] q[$];
    logic [DW-1:0] m_dout = '0;
    logic          m_dv   = 1'b0;
    logic          m_ovf  = 1'b0;
    logic          m_unf  = 1'b0;

    always #5 clk = ~clk;

    sync_fifo_param #(.DATA_W(DW), .ADDR_W(AW), .AF_LEVEL(AFL), .AE_LEVEL(AEL)) dut (
        .clk(clk), .rst(rst), .w_en(w_en), .r_en(r_en), .flush(flush), .clr_err(clr_err),
        .data_in(data_in), .data_out(data_out), .dout_valid(dout_valid), .full(full),
        .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
        .count(count), .overflow(overflow), .underflow(underflow)
    );

    assign dut_flags = {full, empty, almost_full, almost_empty, count, overflow, underflow};

    function automatic logic [10:0] exp_flags();
        int n = q.size();
        return {n == DEPTH, n == 0, n >= AFL, n <= AEL, 5'(n), m_ovf, m_unf};
    endfunction

    function automatic logic exp_dv();
`ifdef SYNC_FIFO_FWFT_EN
        return q.size() != 0;
`else
        return m_dv;
`endif
    endfunction

    function automatic logic [DW-1:0] exp_dout();
`ifdef SYNC_FIFO_FWFT_EN
        return (q.size() != 0) ? q[0] : '0;
`else
        return m_dout;
`endif
    endfunction

    task automatic cycle(input logic w, input logic r, input logic fl, input logic ce,
                         input logic rs, input logic [DW-1:0] d);
        logic was_full;
        logic was_empty;
        w_en = w; r_en = r; flush = fl; clr_err = ce; rst = rs; data_in = d;
        @(posedge clk);
        was_full  = (q.size() == DEPTH);
        was_empty = (q.size() == 0);
        if (!rs) begin
            q.delete(); m_dout = '0; m_dv = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
        end else if (fl) begin
            q.delete(); m_dv = 1'b0;
        end else begin
            m_ovf = (m_ovf && !ce) || (w && was_full);
            m_unf = (m_unf && !ce) || (r && was_empty);
            m_dv  = 1'b0;
            if (r && !was_empty) begin
                m_dout = q.pop_front();
                m_dv   = 1'b1;
            end
            if (w && !was_full) q.push_back(d);
        end
        #1;
        w_en = 1'b0; r_en = 1'b0; flush = 1'b0; clr_err = 1'b0;
    endtask

    task automatic test_reset();
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        total++;
        if (dut_flags !== 11'b01010000000) begin
            bad++; $display("FAIL reset_flags got=%b want=%b", dut_flags, 11'b01010000000);
        end
        total++;
        if (dout_valid !== 1'b0) begin
            bad++; $display("FAIL reset_dv got=%b want=0", dout_valid);
        end
`ifndef SYNC_FIFO_FWFT_EN
        total++;
        if (data_out !== '0) begin
            bad++; $display("FAIL reset_dout got=%h want=0", data_out);
        end
`endif
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, '0);
        $display("test_reset done");
    endtask

    task automatic test_fill_drain();
        for (int i = 1; i <= 16; i++) begin
            cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'(i));
            total++;
            if (dut_flags !== exp_flags()) begin
                bad++; $display("FAIL fill_flags[%0d] got=%b want=%b", i, dut_flags, exp_flags());
            end
        end
        for (int i = 1; i <= 16; i++) begin
            cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, '0);
            total++;
            if (dut_flags !== exp_flags()) begin
                bad++; $display("FAIL drain_flags[%0d] got=%b want=%b", i, dut_flags, exp_flags());
            end
            total++;
            if (dout_valid !== exp_dv() || (exp_dv() && data_out !== exp_dout())) begin
                bad++;
                $display("FAIL drain_data[%0d] got dv=%b d=%h want dv=%b d=%h",
                         i, dout_valid, data_out, exp_dv(), exp_dout());
            end
        end
        total++;
        if (empty !== 1'b1) begin
            bad++; $display("FAIL drain_empty got=%b want=1", empty);
        end
        $display("test_fill_drain done");
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, $urandom);
        total++;
        if (dut_flags !== exp_flags()) begin
            bad++; $display("FAIL ovf_full got=%b want=%b", dut_flags, exp_flags());
        end
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF);
        total++;
        if (dut_flags !== exp_flags()) begin
            bad++; $display("FAIL ovf_flags got=%b want=%b", dut_flags, exp_flags());
        end
        total++;
        if (dout_valid !== exp_dv() || data_out !== exp_dout()) begin
            bad++; $display("FAIL ovf_data got dv=%b d=%h want dv=%b d=%h",
                            dout_valid, data_out, exp_dv(), exp_dout());
        end
        for (int i = 0; i < 15; i++) begin
            cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, '0);
            total++;
            if (dout_valid !== exp_dv() || (exp_dv() && data_out !== exp_dout())) begin
                bad++; $display("FAIL ovf_drain[%0d] got dv=%b d=%h want dv=%b d=%h",
                                i, dout_valid, data_out, exp_dv(), exp_dout());
            end
        end
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, '0);
        total++;
        if (dut_flags !== exp_flags()) begin
            bad++; $display("FAIL ovf_clear got=%b want=%b", dut_flags, exp_flags());
        end
        $display("test_overflow done");
    endtask

    task automatic test_underflow();
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, '0);
        total++;
        if (dut_flags !== exp_flags()) begin
            bad++; $display("FAIL unf_flags got=%b want=%b", dut_flags, exp_flags());
        end
        total++;
        if (dout_valid !== 1'b0) begin
            bad++; $display("FAIL unf_dv got=%b want=0", dout_valid);
        end
`ifndef SYNC_FIFO_FWFT_EN
        total++;
        if (data_out !== m_dout) begin
            bad++; $display("FAIL unf_hold got=%h want=%h", data_out, m_dout);
        end
`endif
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, '0);
        total++;
        if (underflow !== 1'b0) begin
            bad++; $display("FAIL unf_clear got=%b want=0", underflow);
        end
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, '0);
        total++;
        if (underflow !== 1'b1) begin
            bad++; $display("FAIL unf_set_wins got=%b want=1", underflow);
        end
        cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h1234_5678);
        total++;
        if (dut_flags !== exp_flags()) begin
            bad++; $display("FAIL unf_empty_wr got=%b want=%b", dut_flags, exp_flags());
        end
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, '0);
        total++;
        if (dout_valid !== exp_dv() || data_out !== exp_dout() || dut_flags !== exp_flags()) begin
            bad++; $display("FAIL unf_readback got dv=%b d=%h f=%b want dv=%b d=%h f=%b",
                            dout_valid, data_out, dut_flags, exp_dv(), exp_dout(), exp_flags());
        end
        $display("test_underflow done");
    endtask

    task automatic test_wrap();
        int wn = 0;
        int rn = 0;
        logic w;
        logic r;
        for (int c = 0; c < 400 && (wn < 40 || rn < 40); c++) begin
            w = (wn < 40) && (q.size() < DEPTH) && ($urandom_range(0, 1) != 0);
            r = (q.size() > 0) && ($urandom_range(0, 1) != 0);
            if (w) wn++;
            if (r) rn++;
            cycle(w, r, 1'b0, 1'b0, 1'b1, $urandom);
            total++;
            if (dut_flags !== exp_flags()) begin
                bad++; $display("FAIL wrap_flags[%0d] got=%b want=%b", c, dut_flags, exp_flags());
            end
            total++;
            if (dout_valid !== exp_dv() || (exp_dv() && data_out !== exp_dout())) begin
                bad++; $display("FAIL wrap_data[%0d] got dv=%b d=%h want dv=%b d=%h",
                                c, dout_valid, data_out, exp_dv(), exp_dout());
            end
        end
        total++;
        if (wn != 40 || rn != 40) begin
            bad++; $display("FAIL wrap_budget got w=%0d r=%0d want 40/40", wn, rn);
        end
        $display("test_wrap done");
    endtask

    task automatic test_flush_reset();
        if (q.size() == 0) cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, '0);
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, $urandom);
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'hFFFF_0000);
        total++;
        if (dut_flags !== exp_flags()) begin
            bad++; $display("FAIL flush_flags got=%b want=%b", dut_flags, exp_flags());
        end
        total++;
        if (dout_valid !== exp_dv() || (exp_dv() && data_out !== exp_dout())) begin
            bad++; $display("FAIL flush_data got dv=%b d=%h want dv=%b d=%h",
                            dout_valid, data_out, exp_dv(), exp_dout());
        end
`ifndef SYNC_FIFO_FWFT_EN
        total++;
        if (data_out !== m_dout) begin
            bad++; $display("FAIL flush_hold got=%h want=%h", data_out, m_dout);
        end
`endif
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, $urandom);
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, $urandom);
        total++;
        if (dut_flags !== 11'b01010000000 || dout_valid !== 1'b0) begin
            bad++; $display("FAIL midburst_reset got f=%b dv=%b want f=%b dv=0",
                            dut_flags, dout_valid, 11'b01010000000);
        end
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, '0);
        $display("test_flush_reset done");
    endtask

    task automatic test_random();
        logic w;
        logic r;
        for (int c = 0; c < 300; c++) begin
            w = (c < 150) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            r = (c < 150) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            cycle(w, r, $urandom_range(0, 39) == 0, $urandom_range(0, 7) == 0, 1'b1, $urandom);
            total++;
            if (dut_flags !== exp_flags()) begin
                bad++; $display("FAIL rand_flags[%0d] got=%b want=%b", c, dut_flags, exp_flags());
            end
            total++;
            if (dout_valid !== exp_dv() || (exp_dv() && data_out !== exp_dout())) begin
                bad++; $display("FAIL rand_data[%0d] got dv=%b d=%h want dv=%b d=%h",
                                c, dout_valid, data_out, exp_dv(), exp_dout());
            end
        end
        $display("test_random done");
    endtask

`ifdef SYNC_FIFO_FWFT_EN
    task automatic test_fwft();
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, '0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'hA5A5A5A5);
        total++;
        if (dout_valid !== 1'b1 || data_out !== 32'hA5A5A5A5) begin
            bad++; $display("FAIL fwft_head got dv=%b d=%h want dv=1 d=a5a5a5a5", dout_valid, data_out);
        end
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, '0);
        total++;
        if (empty !== 1'b1 || dout_valid !== 1'b0) begin
            bad++; $display("FAIL fwft_pop got empty=%b dv=%b want empty=1 dv=0", empty, dout_valid);
        end
        $display("test_fwft done");
    endtask
`endif

    initial begin
        test_reset();
        test_fill_drain();
        test_overflow();
        test_underflow();
        test_wrap();
        test_flush_reset();
        test_random();
`ifdef SYNC_FIFO_FWFT_EN
        test_fwft();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
